// File: rtl/apb_decoder.sv
// rtl/apb_decoder.sv - APB address decoder/interconnect, one master to NumPorts slaves
// Base/mask window decode (lowest index wins), local error completion for misses, access watchdog.
module apb_decoder #(
    parameter int NumPorts      = 4,
    parameter int AddrBits      = 32,
    parameter int DataBits      = 32,
    parameter logic [NumPorts*AddrBits-1:0] PortBase = '0,
    parameter logic [NumPorts*AddrBits-1:0] PortMask = '0,
    parameter int TimeoutCycles = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AddrBits-1:0]          slv_paddr,
    input  logic                         slv_psel,
    input  logic                         slv_penable,
    output logic                         slv_pready,
    output logic [DataBits-1:0]          slv_prdata,
    output logic                         slv_pslverr,
    output logic [NumPorts-1:0]          mst_psel,
    output logic [NumPorts-1:0]          mst_penable,
    input  logic [NumPorts-1:0]          mst_pready,
    input  logic [NumPorts*DataBits-1:0] mst_prdata,
    input  logic [NumPorts-1:0]          mst_pslverr,
    output logic                         err_unmapped,
    output logic                         err_timeout
);

    localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit WdogEn = (TimeoutCycles > 0);
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] UNMAP  = 2'd2;

    logic [1:0]          state;
    logic [PortW-1:0]    port_q;
    logic [CntW-1:0]     cnt;

    logic                hit;
    logic [PortW-1:0]    dec_port;
    logic                sel_ready;
    logic                sel_err;
    logic [DataBits-1:0] sel_rdata;
    logic                stalled;
    logic                wdog_fire;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        dec_port = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if ((slv_paddr & PortMask[i*AddrBits +: AddrBits]) ==
                (PortBase[i*AddrBits +: AddrBits] & PortMask[i*AddrBits +: AddrBits])) begin
                hit      = 1'b1;
                dec_port = PortW'(i);
            end
        end
    end

    assign sel_ready = mst_pready[port_q];
    assign sel_err   = mst_pslverr[port_q];
    assign sel_rdata = mst_prdata[port_q*DataBits +: DataBits];

    assign stalled   = (state == ACCESS) && slv_psel && slv_penable && !sel_ready;
    // A slave that becomes ready on the final cycle still wins over the watchdog.
    assign wdog_fire = WdogEn && stalled && (cnt == CntLast);

    always_comb begin
        mst_psel    = '0;
        mst_penable = '0;
        slv_pready  = 1'b0;
        slv_prdata  = '0;
        slv_pslverr = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (slv_psel && hit) begin
                        mst_psel[dec_port] = 1'b1;
                    end
                end
                ACCESS: begin
                    mst_psel[port_q]    = slv_psel;
                    mst_penable[port_q] = slv_penable;
                    if (wdog_fire) begin
                        slv_pready  = 1'b1;
                        slv_pslverr = 1'b1;
                    end else begin
                        slv_pready  = sel_ready;
                        slv_prdata  = sel_rdata;
                        slv_pslverr = sel_err & sel_ready;
                    end
                end
                UNMAP: begin
                    slv_pready  = slv_penable;
                    slv_pslverr = slv_penable;
                end
                default: begin
                    slv_pready = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            port_q       <= '0;
            cnt          <= '0;
            err_unmapped <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_unmapped <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (slv_psel && !slv_penable) begin
                        port_q <= dec_port;
                        cnt    <= '0;
                        state  <= hit ? ACCESS : UNMAP;
                    end
                end
                ACCESS: begin
                    if (!slv_psel) begin
                        state <= IDLE;
                    end else begin
                        if (slv_penable && slv_pready) begin
                            state       <= IDLE;
                            err_timeout <= wdog_fire;
                        end
                        if (WdogEn && stalled && (cnt != CntMax)) begin
                            cnt <= cnt + CntW'(1);
                        end
                    end
                end
                UNMAP: begin
                    if (!slv_psel) begin
                        state <= IDLE;
                    end else if (slv_penable) begin
                        state        <= IDLE;
                        err_unmapped <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_decoder.sv
// tb/tb_apb_decoder.sv - self-checking bench for apb_decoder
// Directed tables plus random transfers checked against a window-lookup reference model.
module tb_apb_decoder;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   slv_paddr;
    logic            slv_psel;
    logic            slv_penable;
    logic            slv_pready;
    logic [DW-1:0]   slv_prdata;
    logic            slv_pslverr;
    logic [NP-1:0]   mst_psel;
    logic [NP-1:0]   mst_penable;
    logic [NP-1:0]   mst_pready;
    logic [NP*DW-1:0] mst_prdata;
    logic [NP-1:0]   mst_pslverr;
    logic            err_unmapped;
    logic            err_timeout;

    int errors = 0;
    int checks = 0;

    logic [15:0] bases [NP] = '{16'h0000, 16'h1000, 16'h1800, 16'h8000};
    logic [15:0] masks [NP] = '{16'hF000, 16'hF000, 16'hF800, 16'h8000};

    apb_decoder #(
        .NumPorts(NP), .AddrBits(AW), .DataBits(DW),
        .PortBase({16'h8000, 16'h1800, 16'h1000, 16'h0000}),
        .PortMask({16'h8000, 16'hF800, 16'hF000, 16'hF000}),
        .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .slv_paddr(slv_paddr), .slv_psel(slv_psel), .slv_penable(slv_penable),
        .slv_pready(slv_pready), .slv_prdata(slv_prdata), .slv_pslverr(slv_pslverr),
        .mst_psel(mst_psel), .mst_penable(mst_penable), .mst_pready(mst_pready),
        .mst_prdata(mst_prdata), .mst_pslverr(mst_pslverr),
        .err_unmapped(err_unmapped), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  sel;
    } dvec_t;

    typedef struct {
        logic [15:0] addr;
        int          wt;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        logic [31:0] data;
        logic        perr;
        logic        unm;
        logic        to;
        logic [3:0]  sel;
    } xvec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_port(input logic [15:0] a);
        for (int i = 0; i < NP; i++) begin
            if ((a & masks[i]) == (bases[i] & masks[i])) return i;
        end
        return -1;
    endfunction

    task automatic run_xfer(input xvec_t v);
        int  tgt;
        int  cyc;
        bit  done;
        tgt = -1;
        for (int i = NP - 1; i >= 0; i--) if (v.sel[i]) tgt = i;
        slv_paddr   = v.addr;
        slv_psel    = 1'b1;
        slv_penable = 1'b0;
        mst_pready  = '0;
        #1;
        check("setup_psel", 64'(mst_psel), 64'(v.sel));
        check("setup_pready", 64'(slv_pready), 64'd0);
        @(posedge clk); #1;
        slv_penable = 1'b1;
        slv_paddr   = 16'($urandom);
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 20) begin
            cyc++;
            mst_prdata  = {$urandom, $urandom, $urandom, $urandom};
            mst_pslverr = 4'($urandom);
            mst_pready  = '0;
            if (tgt >= 0) begin
                mst_prdata[tgt*DW +: DW] = v.rdata;
                mst_pslverr[tgt]         = v.err;
                if (cyc > v.wt) mst_pready[tgt] = 1'b1;
            end
            #1;
            if (slv_pready) begin
                done = 1'b1;
                check("cycles", 64'(cyc), 64'(v.cyc));
                check("prdata", 64'(slv_prdata), 64'(v.data));
                check("pslverr", 64'(slv_pslverr), 64'(v.perr));
                check("access_psel", 64'(mst_psel), 64'(v.sel));
                check("access_penable", 64'(mst_penable), 64'(v.sel));
            end else begin
                check("wait_pslverr", 64'(slv_pslverr), 64'd0);
            end
            @(posedge clk); #1;
        end
        if (!done) check("xfer_done", 64'd0, 64'd1);
        slv_psel    = 1'b0;
        slv_penable = 1'b0;
        mst_pready  = '0;
        check("err_unmapped", 64'(err_unmapped), 64'(v.unm));
        check("err_timeout", 64'(err_timeout), 64'(v.to));
    endtask

    function automatic xvec_t model(input logic [15:0] a, input int wt,
                                    input logic [31:0] rd, input logic er);
        xvec_t v;
        int p;
        p = ref_port(a);
        v.addr = a; v.wt = wt; v.rdata = rd; v.err = er;
        v.unm = 1'b0; v.to = 1'b0;
        if (p < 0) begin
            v.sel = 4'b0; v.cyc = 1; v.data = '0; v.perr = 1'b1; v.unm = 1'b1;
        end else begin
            v.sel = 4'(1 << p);
            if (wt < TO) begin
                v.cyc = wt + 1; v.data = rd; v.perr = er;
            end else begin
                v.cyc = TO; v.data = '0; v.perr = 1'b1; v.to = 1'b1;
            end
        end
        return v;
    endfunction

    dvec_t dvecs [11];
    xvec_t xvecs [7];

    initial begin
        dvecs = '{
            '{16'h0000, 4'b0001}, '{16'h0FFF, 4'b0001}, '{16'h1000, 4'b0010},
            '{16'h17FC, 4'b0010}, '{16'h1800, 4'b0010}, '{16'h1FFF, 4'b0010},
            '{16'h2000, 4'b0000}, '{16'h7FFF, 4'b0000}, '{16'h8000, 4'b1000},
            '{16'hFFFF, 4'b1000}, '{16'h9000, 4'b1000}
        };
        xvecs = '{
            '{16'h0004, 0,   32'hDEADBEEF, 1'b0, 1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'b0001},
            '{16'h1804, 3,   32'h12345678, 1'b1, 4, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'b0010},
            '{16'h4000, 0,   32'h11111111, 1'b0, 1, 32'h0,        1'b1, 1'b1, 1'b0, 4'b0000},
            '{16'h9000, 100, 32'h22222222, 1'b0, 8, 32'h0,        1'b1, 1'b0, 1'b1, 4'b1000},
            '{16'h0010, 0,   32'hAAAA5555, 1'b0, 1, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 4'b0001},
            '{16'h1010, 0,   32'h5555AAAA, 1'b0, 1, 32'h5555AAAA, 1'b0, 1'b0, 1'b0, 4'b0010},
            '{16'hC000, 7,   32'h0BADF00D, 1'b0, 8, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 4'b1000}
        };

        rst = 1'b1;
        slv_paddr = 16'h0000; slv_psel = 1'b1; slv_penable = 1'b0;
        mst_pready = '1; mst_prdata = '1; mst_pslverr = '1;
        #1;
        check("rst_psel", 64'(mst_psel), 64'd0);
        check("rst_pready", 64'(slv_pready), 64'd0);
        check("rst_err", 64'({err_unmapped, err_timeout}), 64'd0);
        slv_psel = 1'b0; mst_pready = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (dvecs[i]) begin
            slv_paddr = dvecs[i].addr; slv_psel = 1'b1; slv_penable = 1'b0;
            #1;
            check("decode_psel", 64'(mst_psel), 64'(dvecs[i].sel));
            check("decode_model", 64'(ref_port(dvecs[i].addr)),
                  64'(dvecs[i].sel == 0 ? -1 : $clog2(dvecs[i].sel)));
            slv_psel = 1'b0;
            #1;
        end
        @(posedge clk); #1;

        foreach (xvecs[i]) run_xfer(xvecs[i]);

        for (int n = 0; n < 40; n++) begin
            run_xfer(model(16'($urandom), int'($urandom_range(0, 10)), $urandom, 1'($urandom)));
        end

        slv_paddr = 16'h9000; slv_psel = 1'b1; slv_penable = 1'b0; mst_pready = '0;
        @(posedge clk); #1;
        slv_penable = 1'b1;
        @(posedge clk); #2;
        mst_pready = 4'b1000;
        rst = 1'b1;
        #1;
        check("midrst_psel", 64'(mst_psel), 64'd0);
        check("midrst_penable", 64'(mst_penable), 64'd0);
        check("midrst_resp", 64'({slv_pready, slv_pslverr, slv_prdata}), 64'd0);
        @(posedge clk); #1;
        slv_psel = 1'b0; slv_penable = 1'b0; mst_pready = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        run_xfer(model(16'h0000, 0, 32'hCAFEF00D, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_decoder.md
# apb_decoder

Parametrised APB address decoder and interconnect joining one APB master to `NumPorts` APB slaves.
- **Decode:** each port's address window is set by a base/mask pair; lowest index wins on overlap.
- **Unmapped addresses:** completed locally with an error response.
- **Stuck slaves:** a watchdog terminates the transfer with an error.
- **Placement:** sits between the system APB master (bus bridge) and peripheral register blocks. `paddr`, `pwrite` and `pwdata` are broadcast outside this block.

## Interface
Parameters:
- `NumPorts`, 4, number of downstream slaves (≥1)
- `AddrBits`, 32, APB address width
- `DataBits`, 32, APB data width
- `PortBase`, 0, `NumPorts*AddrBits` packed bases; port i at `[i*AddrBits +: AddrBits]`
- `PortMask`, 0, `NumPorts*AddrBits` packed masks; same packing as `PortBase`
- `TimeoutCycles`, 256, access-phase watchdog limit; 0 disables the watchdog

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `slv_paddr`  in  AddrBits  address from master
- `slv_psel`  in  1  select from master
- `slv_penable`  in  1  enable from master
- `slv_pready`  out  1  ready to master
- `slv_prdata`  out  DataBits  read data to master
- `slv_pslverr`  out  1  error to master
- `mst_psel`  out  NumPorts  per-slave select
- `mst_penable`  out  NumPorts  per-slave enable
- `mst_pready`  in  NumPorts  per-slave ready
- `mst_prdata`  in  NumPorts*DataBits  per-slave read data, port i at `[i*DataBits +: DataBits]`
- `mst_pslverr`  in  NumPorts  per-slave error
- `err_unmapped`  out  1  registered 1-cycle pulse, unmapped transfer completed
- `err_timeout`  out  1  registered 1-cycle pulse, watchdog fired

## Operation
**Decode**
- Port i hits when `(slv_paddr & mask_i) == (base_i & mask_i)`.
- On multiple hits, the lowest index is selected.
- No hit means the transfer is unmapped.

**State machine:** IDLE, ACCESS, UNMAP. Reset state is IDLE.

**IDLE**
- `mst_psel` is combinational one-hot of the decoded port, gated by `slv_psel` and hit.
- `mst_penable` = 0; `slv_pready` = 0.
- On `slv_psel & ~slv_penable` (setup phase):
  - register the port index and clear the watchdog counter;
  - go to ACCESS on hit, UNMAP on miss.

**ACCESS** (latched port p)
- `mst_psel[p]` = `slv_psel`; `mst_penable[p]` = `slv_penable`; all other bits 0.
- `slv_pready` = `mst_pready[p]`; `slv_prdata` = `mst_prdata[p]`; `slv_pslverr` = `mst_pslverr[p] & mst_pready[p]`.
- Completion (`slv_penable & slv_pready`) returns to IDLE.
- Watchdog: each cycle with `slv_penable` = 1 and `mst_pready[p]` = 0 increments the counter.
  - If counter == `TimeoutCycles-1` in such a cycle, force `slv_pready` = 1, `slv_pslverr` = 1 and `slv_prdata` = 0.
  - Assert `err_timeout` the next cycle and return to IDLE.
  - The slave sees `mst_psel` drop (abort).
- `slv_psel` = 0 while in ACCESS (master protocol violation): return to IDLE, no error pulse.

**UNMAP**
- No `mst_psel`/`mst_penable` bits set.
- `slv_pready` = `slv_penable`; `slv_pslverr` = `slv_penable`; `slv_prdata` = 0.
- Completion pulses `err_unmapped` the next cycle and returns to IDLE.
- `slv_psel` = 0 returns to IDLE.

**Outputs outside these rules**
- `slv_prdata` = 0 whenever not in ACCESS.
- `slv_pslverr` = 0 whenever `slv_pready` = 0.

**Widths**
- Counter width is `clog2(TimeoutCycles+1)` (minimum 1); the counter saturates and never wraps.
- Port index width is `clog2(NumPorts)` (minimum 1).

## Timing
- **Reset:** asynchronous `rst` forces IDLE and clears the counter and `err_*` pulses.
  - `mst_psel`, `mst_penable`, `slv_pready`, `slv_prdata`, `slv_pslverr` are all 0 while `rst` is high.
  - A transfer in progress at reset is dropped with no response.
- **Latency:** zero added cycles. A zero-wait slave completes in the standard 2 cycles (setup + access), and `mst_*` control follows the master combinationally.
- **Back-to-back:** after a completion cycle, the next cycle is IDLE and decodes the new setup phase immediately, with no bubble.
- **Address stability:** decode is latched at setup. Address changes during ACCESS do not move the selection.
- **Unmapped response:** completes on the first access cycle (2 cycles total).
- **Timeout response:** error returned on access cycle number `TimeoutCycles`.
  - If `mst_pready` rises in that same cycle, the slave's response wins and no timeout is flagged.
- **Watchdog disabled:** with `TimeoutCycles` = 0 the watchdog is absent and ACCESS waits indefinitely.

## Test plan
Configuration: NumPorts=4, AddrBits=16, DataBits=32, TimeoutCycles=8.
- Port 0: base 0x0000, mask 0xF000.
- Port 1: base 0x1000, mask 0xF000.
- Port 2: base 0x1800, mask 0xF800.
- Port 3: base 0x8000, mask 0x8000.

Scenarios:
1. Read 0x0004, port0 ready immediately with prdata 0xDEADBEEF -> setup `mst_psel`=0001; access `mst_penable`=0001, `slv_pready`=1, `slv_prdata`=0xDEADBEEF, `slv_pslverr`=0; total 2 cycles.
2. Access 0x1804 (overlaps ports 1 and 2), port1 holds `pready` low 3 cycles, then high with `pslverr`=1 -> only `mst_psel[1]` asserted; `slv_pready` high on the 4th access cycle with `slv_pslverr`=1; no `err_*`.
3. Access 0x4000 -> `mst_psel`=0000 throughout; access cycle `slv_pready`=1, `slv_pslverr`=1, `slv_prdata`=0; `err_unmapped` pulses once.
4. Access 0x9000, port3 never ready -> access cycles 1–7 `slv_pready`=0; cycle 8 `slv_pready`=1, `slv_pslverr`=1; `err_timeout` pulses next cycle; `mst_psel` returns to 0000.
5. Back-to-back: 0x0010 then 0x1010, both zero-wait -> 4 cycles total; second setup drives `mst_psel`=0010 in the cycle right after the first completion.
6. `rst` asserted mid-cycle during ACCESS to port3 -> all outputs 0 immediately (asynchronous); after release, a transfer to 0x0000 completes normally.
